tl_ul_arbiter_2to1: RTL and testbench
=====================================

# tl_ul_arbiter_2to1

Two-client TileLink-UL arbiter that shares one downstream A/D port, such as the port feeding a FIFO fixer and monitor stage, between two upstream masters. It arbitrates the A channel per message, holding the grant for the whole multi-beat burst. It widens the source ID by one bit to tag the client and steers D-channel responses back by that tag. Per-client outstanding-request counters throttle each master to a fixed limit.

## Interface
- MAX_OUTSTANDING, 4: max in-flight requests per client; legal range 1..7.
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; state clears on a rising edge while reset==0.
- auto_in{0,1}_a_ready  out  1  client A accept.
- auto_in{0,1}_a_valid  in  1  client A request.
- auto_in{0,1}_a_bits_{opcode,param,size}  in  3 each  TL A fields.
- auto_in{0,1}_a_bits_source  in  5  client source ID.
- auto_in{0,1}_a_bits_{address,mask,data,corrupt}  in  13/8/64/1  TL A payload.
- auto_in{0,1}_d_ready  in  1  client D accept.
- auto_in{0,1}_d_valid  out  1  routed D response.
- auto_in{0,1}_d_bits_{opcode,size}  out  3 each; auto_in{0,1}_d_bits_source  out  5; auto_in{0,1}_d_bits_data  out  64.
- auto_out_a_ready  in  1; auto_out_a_valid  out  1.
- auto_out_a_bits_{opcode,param,size}  out  3 each; auto_out_a_bits_source  out  6 = {client, in source}; address/mask/data/corrupt  out  13/8/64/1.
- auto_out_d_ready  out  1; auto_out_d_valid  in  1; auto_out_d_bits_{opcode,size}  in  3 each; auto_out_d_bits_source  in  6; auto_out_d_bits_data  in  64.

## Operation
- Beat count: A opcodes 0/1 (PutFull/PutPartial) and D opcode 1 (AccessAckData) take max(1, 2^size/8) beats; all others take 1. Size is at most 6, so the 3-bit beat counters are sufficient.
- Eligibility: client i is eligible when a_valid_i is high and outstanding_i < MAX_OUTSTANDING.
- State machine states:
  - IDLE: grant goes to an eligible client. With both eligible, the round-robin pointer wins. A first beat accepted, i.e. out_a_valid && out_a_ready, moves to BURST if beats > 1; otherwise stay in IDLE.
  - BURST: grant is locked to the owner regardless of eligibility. Beats are counted on each accepted beat, and the last accepted beat returns to IDLE.
- Pointer: after the last beat of a message from client i, pointer = 1-i.
- A muxing: out_a = granted client's bits with source = {i, src}. in_a_ready_i = out_a_ready && granted_i. The non-granted client's ready is 0.
- outstanding_i: +1 on the accepted first A beat of client i. −1 on the accepted last D beat with source[5]==i. Simultaneous +1/−1 leaves it unchanged. Saturation at 0 and at MAX cannot occur in legal traffic.
- D routing: combinational. in_d_valid_i = out_d_valid && source[5]==i. in_d_bits_source = source[4:0]. out_d_ready = in_d_ready of source[5].
- D beat counter: one shared counter tracks multi-beat responses. Beats of a D message are contiguous, so a single counter is enough.

## Timing
- Zero-latency combinational A and D paths. No registers on the data path.
- Grant in IDLE is combinational from the current-cycle valid signals. State, pointer and counters register at the clock edge.
- A valid must not drop mid-burst; the block does not check this.
- While reset==0, all four valid/ready outputs are forced to 0.
- Reset values: state=IDLE, pointer=client0, outstanding_0=outstanding_1=0, beat counters=0.
- Reset mid-burst abandons the burst. After release, arbitration restarts in IDLE.

## Configuration
- TLARB_FIXED_PRIO_EN defined: client0 always wins in IDLE when eligible, and the pointer is unused.
- TLARB_FIXED_PRIO_EN undefined: round-robin as specified above.
- Burst locking and throttling are identical in both modes.

## Test plan
- Both clients issue a single-beat Get (size 3) every cycle with out_a_ready=1 -> grants alternate 0,1,0,1, and out source[5] toggles each cycle.
- Client0 issues PutFull size 6 while client1 is valid throughout -> 8 consecutive client0 beats, in1_a_ready=0 for all 8, then client1 is granted next.
- Client1 issues 4 Gets with no D returned (MAX_OUTSTANDING=4) -> the 5th request sees in1_a_ready=0. One AccessAckData (size 3) to source 0x20 -> ready=1 the next cycle.
- D beats with sources 0x05 and 0x25 -> delivered to in0 and in1 respectively with source 0x05. Dropping in1_d_ready stalls out_d_ready only while source[5]=1.
- Assert reset=0 on beat 3 of an 8-beat Put -> outputs 0 during reset. After release, a client1 Get is granted immediately and outstanding counts restart from 0.
- With TLARB_FIXED_PRIO_EN defined and both clients continuously valid -> client0 granted every cycle until its outstanding count reaches 4.

Source files
------------

// File: rtl/tl_ul_arbiter_2to1.sv
// tl_ul_arbiter_2to1: two-client TileLink-UL arbiter onto one A/D port.
// Define TLARB_FIXED_PRIO_EN for fixed client0 priority; round-robin otherwise.
module tl_ul_arbiter_2to1 #(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic        auto_in0_a_ready,
    input  logic        auto_in0_a_valid,
    input  logic [2:0]  auto_in0_a_bits_opcode,
    input  logic [2:0]  auto_in0_a_bits_param,
    input  logic [2:0]  auto_in0_a_bits_size,
    input  logic [4:0]  auto_in0_a_bits_source,
    input  logic [12:0] auto_in0_a_bits_address,
    input  logic [7:0]  auto_in0_a_bits_mask,
    input  logic [63:0] auto_in0_a_bits_data,
    input  logic        auto_in0_a_bits_corrupt,
    input  logic        auto_in0_d_ready,
    output logic        auto_in0_d_valid,
    output logic [2:0]  auto_in0_d_bits_opcode,
    output logic [2:0]  auto_in0_d_bits_size,
    output logic [4:0]  auto_in0_d_bits_source,
    output logic [63:0] auto_in0_d_bits_data,
    output logic        auto_in1_a_ready,
    input  logic        auto_in1_a_valid,
    input  logic [2:0]  auto_in1_a_bits_opcode,
    input  logic [2:0]  auto_in1_a_bits_param,
    input  logic [2:0]  auto_in1_a_bits_size,
    input  logic [4:0]  auto_in1_a_bits_source,
    input  logic [12:0] auto_in1_a_bits_address,
    input  logic [7:0]  auto_in1_a_bits_mask,
    input  logic [63:0] auto_in1_a_bits_data,
    input  logic        auto_in1_a_bits_corrupt,
    input  logic        auto_in1_d_ready,
    output logic        auto_in1_d_valid,
    output logic [2:0]  auto_in1_d_bits_opcode,
    output logic [2:0]  auto_in1_d_bits_size,
    output logic [4:0]  auto_in1_d_bits_source,
    output logic [63:0] auto_in1_d_bits_data,
    input  logic        auto_out_a_ready,
    output logic        auto_out_a_valid,
    output logic [2:0]  auto_out_a_bits_opcode,
    output logic [2:0]  auto_out_a_bits_param,
    output logic [2:0]  auto_out_a_bits_size,
    output logic [5:0]  auto_out_a_bits_source,
    output logic [12:0] auto_out_a_bits_address,
    output logic [7:0]  auto_out_a_bits_mask,
    output logic [63:0] auto_out_a_bits_data,
    output logic        auto_out_a_bits_corrupt,
    output logic        auto_out_d_ready,
    input  logic        auto_out_d_valid,
    input  logic [2:0]  auto_out_d_bits_opcode,
    input  logic [2:0]  auto_out_d_bits_size,
    input  logic [5:0]  auto_out_d_bits_source,
    input  logic [63:0] auto_out_d_bits_data
);

    typedef enum logic {S_IDLE, S_BURST} state_e;

    localparam logic [2:0] MAX_Q = 3'(MAX_OUTSTANDING);

    // Index of the last beat: 2^size/8 - 1 for data-carrying messages.
    function automatic logic [2:0] last_beat(input logic multi,
                                             input logic [2:0] size);
        logic [2:0] r;
        r = 3'd0;
        if (multi) begin
            case (size)
                3'd4:       r = 3'd1;
                3'd5:       r = 3'd3;
                3'd6, 3'd7: r = 3'd7;
                default:    r = 3'd0;
            endcase
        end
        return r;
    endfunction

    state_e     state_q;
    logic       owner_q;
    logic [2:0] abeat_q;
    logic [2:0] dbeat_q;
    logic [2:0] cnt0_q, cnt0_d;
    logic [2:0] cnt1_q, cnt1_d;
`ifndef TLARB_FIXED_PRIO_EN
    logic       ptr_q;
`endif

    logic elig0, elig1, idle_any, idle_sel, burst, sel;
    logic a_vld, a_fire, a_last;
    logic [2:0] a_op, a_sz, a_last_idx;
    logic d_sel, d_rdy, d_fire, d_last;
    logic inc0, inc1, dec0, dec1;

    assign elig0    = auto_in0_a_valid && (cnt0_q < MAX_Q);
    assign elig1    = auto_in1_a_valid && (cnt1_q < MAX_Q);
    assign idle_any = elig0 || elig1;
`ifdef TLARB_FIXED_PRIO_EN
    assign idle_sel = !elig0;
`else
    assign idle_sel = (elig0 && elig1) ? ptr_q : elig1;
`endif
    assign burst = (state_q == S_BURST);
    assign sel   = burst ? owner_q : idle_sel;

    // A channel: the granted client's message passes straight through.
    assign a_vld = burst ? (sel ? auto_in1_a_valid : auto_in0_a_valid)
                         : idle_any;
    assign a_op  = sel ? auto_in1_a_bits_opcode : auto_in0_a_bits_opcode;
    assign a_sz  = sel ? auto_in1_a_bits_size : auto_in0_a_bits_size;

    assign auto_out_a_valid        = reset && a_vld;
    assign auto_out_a_bits_opcode  = a_op;
    assign auto_out_a_bits_size    = a_sz;
    assign auto_out_a_bits_param   = sel ? auto_in1_a_bits_param
                                         : auto_in0_a_bits_param;
    assign auto_out_a_bits_source  = sel ? {1'b1, auto_in1_a_bits_source}
                                         : {1'b0, auto_in0_a_bits_source};
    assign auto_out_a_bits_address = sel ? auto_in1_a_bits_address
                                         : auto_in0_a_bits_address;
    assign auto_out_a_bits_mask    = sel ? auto_in1_a_bits_mask
                                         : auto_in0_a_bits_mask;
    assign auto_out_a_bits_data    = sel ? auto_in1_a_bits_data
                                         : auto_in0_a_bits_data;
    assign auto_out_a_bits_corrupt = sel ? auto_in1_a_bits_corrupt
                                         : auto_in0_a_bits_corrupt;

    assign auto_in0_a_ready = reset && a_vld && auto_out_a_ready && !sel;
    assign auto_in1_a_ready = reset && a_vld && auto_out_a_ready && sel;

    assign a_fire     = auto_out_a_valid && auto_out_a_ready;
    assign a_last_idx = last_beat(a_op[2:1] == 2'b00, a_sz);
    assign a_last     = burst ? (abeat_q == a_last_idx) : (a_last_idx == 3'd0);

    // D channel: steered back by the client tag in source[5].
    assign d_sel = auto_out_d_bits_source[5];
    assign d_rdy = d_sel ? auto_in1_d_ready : auto_in0_d_ready;

    assign auto_out_d_ready = reset && d_rdy;
    assign auto_in0_d_valid = reset && auto_out_d_valid && !d_sel;
    assign auto_in1_d_valid = reset && auto_out_d_valid && d_sel;

    assign auto_in0_d_bits_opcode = auto_out_d_bits_opcode;
    assign auto_in0_d_bits_size   = auto_out_d_bits_size;
    assign auto_in0_d_bits_source = auto_out_d_bits_source[4:0];
    assign auto_in0_d_bits_data   = auto_out_d_bits_data;
    assign auto_in1_d_bits_opcode = auto_out_d_bits_opcode;
    assign auto_in1_d_bits_size   = auto_out_d_bits_size;
    assign auto_in1_d_bits_source = auto_out_d_bits_source[4:0];
    assign auto_in1_d_bits_data   = auto_out_d_bits_data;

    assign d_fire = auto_out_d_valid && auto_out_d_ready;
    assign d_last = dbeat_q == last_beat(auto_out_d_bits_opcode == 3'd1,
                                         auto_out_d_bits_size);

    assign inc0 = a_fire && !burst && !sel;
    assign inc1 = a_fire && !burst && sel;
    assign dec0 = d_fire && d_last && !d_sel;
    assign dec1 = d_fire && d_last && d_sel;

    // Outstanding counters: simultaneous issue and completion cancel out.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (inc0 && !dec0) cnt0_d = cnt0_q + 3'd1;
        if (dec0 && !inc0) cnt0_d = cnt0_q - 3'd1;
        if (inc1 && !dec1) cnt1_d = cnt1_q + 3'd1;
        if (dec1 && !inc1) cnt1_d = cnt1_q - 3'd1;
    end

    // Grant FSM, burst/response beat tracking and outstanding counts.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            abeat_q <= 3'd0;
            dbeat_q <= 3'd0;
            cnt0_q  <= 3'd0;
            cnt1_q  <= 3'd0;
`ifndef TLARB_FIXED_PRIO_EN
            ptr_q   <= 1'b0;
`endif
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
            if (a_fire) begin
                if (!burst) begin
                    if (!a_last) begin
                        state_q <= S_BURST;
                        owner_q <= sel;
                        abeat_q <= 3'd1;
                    end
                end else if (a_last) begin
                    state_q <= S_IDLE;
                    abeat_q <= 3'd0;
                end else begin
                    abeat_q <= abeat_q + 3'd1;
                end
`ifndef TLARB_FIXED_PRIO_EN
                if (a_last) ptr_q <= !sel;
`endif
            end
            if (d_fire) begin
                dbeat_q <= d_last ? 3'd0 : dbeat_q + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_tl_ul_arbiter_2to1.sv
// tb_tl_ul_arbiter_2to1: directed checks of grant, burst lock,
// throttling, D routing and reset for tl_ul_arbiter_2to1.
module tb_tl_ul_arbiter_2to1;

    logic        clock, reset;
    logic        in0_a_ready, in0_a_valid, in0_a_corrupt;
    logic [2:0]  in0_a_opcode, in0_a_param, in0_a_size;
    logic [4:0]  in0_a_source;
    logic [12:0] in0_a_address;
    logic [7:0]  in0_a_mask;
    logic [63:0] in0_a_data;
    logic        in0_d_ready, in0_d_valid;
    logic [2:0]  in0_d_opcode, in0_d_size;
    logic [4:0]  in0_d_source;
    logic [63:0] in0_d_data;
    logic        in1_a_ready, in1_a_valid, in1_a_corrupt;
    logic [2:0]  in1_a_opcode, in1_a_param, in1_a_size;
    logic [4:0]  in1_a_source;
    logic [12:0] in1_a_address;
    logic [7:0]  in1_a_mask;
    logic [63:0] in1_a_data;
    logic        in1_d_ready, in1_d_valid;
    logic [2:0]  in1_d_opcode, in1_d_size;
    logic [4:0]  in1_d_source;
    logic [63:0] in1_d_data;
    logic        out_a_ready, out_a_valid, out_a_corrupt;
    logic [2:0]  out_a_opcode, out_a_param, out_a_size;
    logic [5:0]  out_a_source;
    logic [12:0] out_a_address;
    logic [7:0]  out_a_mask;
    logic [63:0] out_a_data;
    logic        out_d_ready, out_d_valid;
    logic [2:0]  out_d_opcode, out_d_size;
    logic [5:0]  out_d_source;
    logic [63:0] out_d_data;

    int n_cmp = 0;
    int n_bad = 0;

    tl_ul_arbiter_2to1 #(.MAX_OUTSTANDING(4)) dut (
        .clock(clock), .reset(reset),
        .auto_in0_a_ready(in0_a_ready), .auto_in0_a_valid(in0_a_valid),
        .auto_in0_a_bits_opcode(in0_a_opcode),
        .auto_in0_a_bits_param(in0_a_param),
        .auto_in0_a_bits_size(in0_a_size),
        .auto_in0_a_bits_source(in0_a_source),
        .auto_in0_a_bits_address(in0_a_address),
        .auto_in0_a_bits_mask(in0_a_mask),
        .auto_in0_a_bits_data(in0_a_data),
        .auto_in0_a_bits_corrupt(in0_a_corrupt),
        .auto_in0_d_ready(in0_d_ready), .auto_in0_d_valid(in0_d_valid),
        .auto_in0_d_bits_opcode(in0_d_opcode),
        .auto_in0_d_bits_size(in0_d_size),
        .auto_in0_d_bits_source(in0_d_source),
        .auto_in0_d_bits_data(in0_d_data),
        .auto_in1_a_ready(in1_a_ready), .auto_in1_a_valid(in1_a_valid),
        .auto_in1_a_bits_opcode(in1_a_opcode),
        .auto_in1_a_bits_param(in1_a_param),
        .auto_in1_a_bits_size(in1_a_size),
        .auto_in1_a_bits_source(in1_a_source),
        .auto_in1_a_bits_address(in1_a_address),
        .auto_in1_a_bits_mask(in1_a_mask),
        .auto_in1_a_bits_data(in1_a_data),
        .auto_in1_a_bits_corrupt(in1_a_corrupt),
        .auto_in1_d_ready(in1_d_ready), .auto_in1_d_valid(in1_d_valid),
        .auto_in1_d_bits_opcode(in1_d_opcode),
        .auto_in1_d_bits_size(in1_d_size),
        .auto_in1_d_bits_source(in1_d_source),
        .auto_in1_d_bits_data(in1_d_data),
        .auto_out_a_ready(out_a_ready), .auto_out_a_valid(out_a_valid),
        .auto_out_a_bits_opcode(out_a_opcode),
        .auto_out_a_bits_param(out_a_param),
        .auto_out_a_bits_size(out_a_size),
        .auto_out_a_bits_source(out_a_source),
        .auto_out_a_bits_address(out_a_address),
        .auto_out_a_bits_mask(out_a_mask),
        .auto_out_a_bits_data(out_a_data),
        .auto_out_a_bits_corrupt(out_a_corrupt),
        .auto_out_d_ready(out_d_ready), .auto_out_d_valid(out_d_valid),
        .auto_out_d_bits_opcode(out_d_opcode),
        .auto_out_d_bits_size(out_d_size),
        .auto_out_d_bits_source(out_d_source),
        .auto_out_d_bits_data(out_d_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clock);
        #1;
    endtask

    task automatic set_a0(input logic v, input logic [2:0] op,
                          input logic [2:0] sz, input logic [4:0] src);
        in0_a_valid  = v;
        in0_a_opcode = op;
        in0_a_size   = sz;
        in0_a_source = src;
    endtask

    task automatic set_a1(input logic v, input logic [2:0] op,
                          input logic [2:0] sz, input logic [4:0] src);
        in1_a_valid  = v;
        in1_a_opcode = op;
        in1_a_size   = sz;
        in1_a_source = src;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        set_a0(1'b0, 3'd4, 3'd3, 5'd0);
        set_a1(1'b0, 3'd4, 3'd3, 5'd0);
        out_d_valid = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        in0_a_param = 3'd0; in0_a_address = 13'h0100;
        in0_a_mask = 8'hFF; in0_a_data = 64'hA0A0_0000_0000_00A0;
        in0_a_corrupt = 1'b0; in0_d_ready = 1'b1;
        in1_a_param = 3'd0; in1_a_address = 13'h0200;
        in1_a_mask = 8'hFF; in1_a_data = 64'hB1B1_0000_0000_00B1;
        in1_a_corrupt = 1'b0; in1_d_ready = 1'b1;
        out_a_ready = 1'b1;
        out_d_opcode = 3'd0; out_d_size = 3'd3;
        out_d_source = 6'h05; out_d_data = 64'h0;
        set_a0(1'b1, 3'd4, 3'd3, 5'h03);
        set_a1(1'b1, 3'd4, 3'd3, 5'h07);
        out_d_valid = 1'b1;

        // outputs held low while in reset
        #4;
        chk("rst_in0_a_ready", in0_a_ready, 1'b0);
        chk("rst_in1_a_ready", in1_a_ready, 1'b0);
        chk("rst_out_a_valid", out_a_valid, 1'b0);
        chk("rst_in0_d_valid", in0_d_valid, 1'b0);
        chk("rst_out_d_ready", out_d_ready, 1'b0);
        cyc();
        cyc();
        reset = 1'b1;
        out_d_valid = 1'b0;

`ifdef TLARB_FIXED_PRIO_EN
        // client0 wins until throttled at 4 outstanding
        for (int k = 0; k < 4; k++) begin
            #4;
            chk("fp_in0_ready", in0_a_ready, 1'b1);
            chk("fp_in1_ready", in1_a_ready, 1'b0);
            cyc();
        end
        #4;
        chk("fp_in0_throttled", in0_a_ready, 1'b0);
        chk("fp_in1_granted", in1_a_ready, 1'b1);
        cyc();
`else
        // round-robin alternation of single-beat Gets
        for (int k = 0; k < 4; k++) begin
            #4;
            chk("rr_src", out_a_source, (k % 2 == 1) ? 6'h27 : 6'h03);
            chk("rr_in0_ready", in0_a_ready, (k % 2 == 0) ? 1'b1 : 1'b0);
            chk("rr_in1_ready", in1_a_ready, (k % 2 == 1) ? 1'b1 : 1'b0);
            chk("rr_data", out_a_data, (k % 2 == 1) ? 64'hB1B1_0000_0000_00B1
                                                   : 64'hA0A0_0000_0000_00A0);
            cyc();
        end
`endif
        do_reset();

        // 8-beat PutFull from client0 with one stall cycle
        set_a0(1'b1, 3'd0, 3'd6, 5'h01);
        set_a1(1'b1, 3'd4, 3'd3, 5'h02);
        for (int b = 0; b < 8; b++) begin
            if (b == 4) begin
                out_a_ready = 1'b0;
                #4;
                chk("stall_in0_ready", in0_a_ready, 1'b0);
                chk("stall_in1_ready", in1_a_ready, 1'b0);
                chk("stall_out_valid", out_a_valid, 1'b1);
                chk("stall_src", out_a_source, 6'h01);
                cyc();
                out_a_ready = 1'b1;
            end
            #4;
            chk("burst_in0_ready", in0_a_ready, 1'b1);
            chk("burst_in1_ready", in1_a_ready, 1'b0);
            chk("burst_opcode", out_a_opcode, 3'd0);
            cyc();
        end
        set_a0(1'b1, 3'd4, 3'd3, 5'h01);
        #4;
        chk("post_burst_in1_ready", in1_a_ready, 1'b1);
        chk("post_burst_in0_ready", in0_a_ready, 1'b0);
        chk("post_burst_src", out_a_source, 6'h22);
        cyc();
        do_reset();

        // throttling of client1 at 4 outstanding
        set_a1(1'b1, 3'd4, 3'd3, 5'h00);
        for (int k = 0; k < 4; k++) begin
            #4;
            chk("thr_in1_ready", in1_a_ready, 1'b1);
            cyc();
        end
        #4;
        chk("thr_blocked_ready", in1_a_ready, 1'b0);
        chk("thr_blocked_valid", out_a_valid, 1'b0);
        cyc();
        out_d_valid = 1'b1; out_d_opcode = 3'd1; out_d_size = 3'd3;
        out_d_source = 6'h20; out_d_data = 64'h0000_0000_DEAD_BEEF;
        #4;
        chk("ack_in1_d_valid", in1_d_valid, 1'b1);
        chk("ack_in0_d_valid", in0_d_valid, 1'b0);
        chk("ack_in1_d_source", in1_d_source, 5'h00);
        chk("ack_out_d_ready", out_d_ready, 1'b1);
        chk("ack_same_cycle_ready", in1_a_ready, 1'b0);
        cyc();
        out_d_valid = 1'b0;
        #4;
        chk("ack_next_ready", in1_a_ready, 1'b1);
        cyc();
        // two-beat AccessAckData frees a slot only after its last beat
        set_a1(1'b0, 3'd4, 3'd3, 5'h00);
        out_d_valid = 1'b1; out_d_size = 3'd4;
        #4;
        cyc();
        set_a1(1'b1, 3'd4, 3'd3, 5'h00);
        #4;
        chk("mb_mid_ready", in1_a_ready, 1'b0);
        chk("mb_beat2_valid", in1_d_valid, 1'b1);
        cyc();
        out_d_valid = 1'b0;
        #4;
        chk("mb_after_ready", in1_a_ready, 1'b1);
        cyc();
        set_a1(1'b0, 3'd4, 3'd3, 5'h00);

        // D routing by source[5]
        out_d_valid = 1'b1; out_d_opcode = 3'd0; out_d_size = 3'd3;
        out_d_source = 6'h05; out_d_data = 64'h0000_0000_0000_1234;
        #4;
        chk("d0_valid", in0_d_valid, 1'b1);
        chk("d0_other", in1_d_valid, 1'b0);
        chk("d0_source", in0_d_source, 5'h05);
        chk("d0_data", in0_d_data, 64'h1234);
        cyc();
        out_d_source = 6'h25;
        #4;
        chk("d1_valid", in1_d_valid, 1'b1);
        chk("d1_other", in0_d_valid, 1'b0);
        chk("d1_source", in1_d_source, 5'h05);
        chk("d1_out_ready", out_d_ready, 1'b1);
        cyc();
        in1_d_ready = 1'b0;
        #4;
        chk("d1_stall", out_d_ready, 1'b0);
        cyc();
        out_d_source = 6'h05;
        #4;
        chk("d0_no_stall", out_d_ready, 1'b1);
        cyc();
        in1_d_ready = 1'b1;
        do_reset();

        // reset in the middle of an 8-beat Put
        set_a0(1'b1, 3'd0, 3'd6, 5'h09);
        set_a1(1'b1, 3'd4, 3'd3, 5'h0A);
        for (int b = 0; b < 2; b++) begin
            #4;
            chk("mr_in0_ready", in0_a_ready, 1'b1);
            cyc();
        end
        reset = 1'b0;
        #4;
        chk("mr_in0_ready_rst", in0_a_ready, 1'b0);
        chk("mr_in1_ready_rst", in1_a_ready, 1'b0);
        chk("mr_out_valid_rst", out_a_valid, 1'b0);
        cyc();
        reset = 1'b1;
        set_a0(1'b0, 3'd0, 3'd6, 5'h09);
        #4;
        chk("mr_in1_granted", in1_a_ready, 1'b1);
        chk("mr_src", out_a_source, 6'h2A);
        cyc();
        set_a1(1'b0, 3'd4, 3'd3, 5'h0A);
        set_a0(1'b1, 3'd4, 3'd3, 5'h09);
        for (int k = 0; k < 4; k++) begin
            #4;
            chk("mr_cnt_ready", in0_a_ready, 1'b1);
            cyc();
        end
        #4;
        chk("mr_cnt_full", in0_a_ready, 1'b0);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
